// File: rtl/ex_muldiv_if.sv
// Execute-stage bus: operands and destination from id_ex, result and stall to ex_mem/controller.
interface ex_muldiv_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   logic                  flush_i;
   logic [4:0]            op_i;
   logic [XLEN-1:0]       reg1_i;
   logic [XLEN-1:0]       reg2_i;
   logic [REG_ADDR_W-1:0] wd_i;
   logic                  wreg_i;
   logic [REG_ADDR_W-1:0] wd_o;
   logic                  wreg_o;
   logic [XLEN-1:0]       wdata_o;
   logic                  stall_req_o;

   // Pipeline side: issues the instruction, receives the result.
   modport master (
      output flush_i, op_i, reg1_i, reg2_i, wd_i, wreg_i,
      input  wd_o, wreg_o, wdata_o, stall_req_o
   );

   // Execute stage side.
   modport slave (
      input  flush_i, op_i, reg1_i, reg2_i, wd_i, wreg_i,
      output wd_o, wreg_o, wdata_o, stall_req_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// bittyCore execute stage: single-cycle ALU plus iterative radix-2 multiply/divide.
// Multi-cycle ops hold stall_req_o until the result is presented for one cycle.
module ex_muldiv #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 6
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   localparam int unsigned SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [4:0] {
      OP_NOP    = 5'd0,
      OP_OR     = 5'd1,
      OP_AND    = 5'd2,
      OP_XOR    = 5'd3,
      OP_ADD    = 5'd4,
      OP_SUB    = 5'd5,
      OP_SLL    = 5'd6,
      OP_SRL    = 5'd7,
      OP_SRA    = 5'd8,
      OP_SLT    = 5'd9,
      OP_SLTU   = 5'd10,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19,
      OP_DIV    = 5'd20,
      OP_DIVU   = 5'd21,
      OP_REM    = 5'd22,
      OP_REMU   = 5'd23
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   logic [4:0]             op;
   logic [XLEN-1:0]        a;
   logic [XLEN-1:0]        b;
   logic signed [XLEN-1:0] a_s;
   logic [SHW-1:0]         shamt;
   logic [XLEN-1:0]        alu_res;

   assign op    = bus.op_i;
   assign a     = bus.reg1_i;
   assign b     = bus.reg2_i;
   assign a_s   = $signed(a);
   assign shamt = b[SHW-1:0];

   // Single-cycle integer ALU, purely combinational from the operands.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_OR:   alu_res = a | b;
         OP_AND:  alu_res = a & b;
         OP_XOR:  alu_res = a ^ b;
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $unsigned(a_s >>> shamt);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
         default: alu_res = '0;
      endcase
   end

   // M-op decode: low three opcode bits select MUL..REMU.
   logic            is_mop;
   logic [2:0]      mop;
   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            div_zero, div_ovf, special;

   assign is_mop   = (op[4:3] == 2'b10);
   assign mop      = op[2:0];
   assign a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   assign b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign a_neg    = a_sgn & a[XLEN-1];
   assign b_neg    = b_sgn & b[XLEN-1];
   assign a_abs    = a_neg ? -a : a;
   assign b_abs    = b_neg ? -b : b;
   assign div_zero = mop[2] && (b == '0);
   assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
   assign special  = div_zero | div_ovf;

   state_t          state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] acc_hi, acc_lo, opb;
   logic [2:0]      mop_q;
   logic            neg_q, neg_r;
   logic            load, step;

   // acc_hi:acc_lo is the product register for multiply and remainder:quotient for divide.
   logic [XLEN:0] mul_sum, div_sh, div_diff;
   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
   assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
   assign div_diff = div_sh - {1'b0, opb};

   // Datapath: operand latch on issue, one radix-2 step per BUSY cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opb    <= '0;
         mop_q  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (load) begin
         mop_q <= mop;
         cnt   <= CNT_W'(XLEN);
         if (special) begin
            // Both halves are preloaded so quotient and remainder selects both see their answer.
            acc_hi <= div_zero ? a : '0;
            acc_lo <= div_zero ? '1 : MIN_NEG;
            opb    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
         end else begin
            acc_hi <= '0;
            acc_lo <= a_abs;
            opb    <= b_abs;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
         end
      end else if (step) begin
         cnt <= cnt - CNT_W'(1);
         if (!mop_q[2]) begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
         end else if (!div_diff[XLEN]) begin
            acc_hi <= div_diff[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            acc_hi <= div_sh[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
         end
      end
   end

   logic [2*XLEN-1:0] prod, prod_c;
   logic [XLEN-1:0]   quo, rem, mres;
   assign prod   = {acc_hi, acc_lo};
   assign prod_c = neg_q ? -prod : prod;
   assign quo    = neg_q ? -acc_lo : acc_lo;
   assign rem    = neg_r ? -acc_hi : acc_hi;

   // Sign-corrected M-op result selection from the registered datapath.
   always_comb begin
      mres = '0;
      case (mop_q)
         3'd0:             mres = prod_c[XLEN-1:0];
         3'd1, 3'd2, 3'd3: mres = prod_c[2*XLEN-1:XLEN];
         3'd4, 3'd5:       mres = quo;
         default:          mres = rem;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   logic            stall, wreg;
   logic [XLEN-1:0] wdata;

   // FSM next state and outputs; flush then reset override everything.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      stall     = 1'b0;
      wreg      = bus.wreg_i;
      wdata     = alu_res;
      case (state)
         S_IDLE: begin
            if (is_mop) begin
               stall     = 1'b1;
               wreg      = 1'b0;
               wdata     = '0;
               load      = 1'b1;
               state_nxt = special ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            wreg  = 1'b0;
            wdata = '0;
            step  = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = S_DONE;
         end
         S_DONE: begin
            wdata     = mres;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (bus.flush_i) begin
         state_nxt = S_IDLE;
         load      = 1'b0;
         step      = 1'b0;
         stall     = 1'b0;
         wreg      = 1'b0;
      end
      if (rst) begin
         load  = 1'b0;
         step  = 1'b0;
         stall = 1'b0;
         wreg  = 1'b0;
         wdata = '0;
      end
   end

   assign bus.wd_o        = rst ? '0 : bus.wd_i;
   assign bus.wreg_o      = wreg;
   assign bus.wdata_o     = wdata;
   assign bus.stall_req_o = stall;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv at XLEN=32 with hand-computed expected values.
module tb_ex_muldiv;
   localparam logic [4:0] NOP = 5'd0, OR_ = 5'd1, AND_ = 5'd2, XOR_ = 5'd3, ADD = 5'd4,
                          SUB = 5'd5, SLL = 5'd6, SRL = 5'd7, SRA = 5'd8, SLT = 5'd9,
                          SLTU = 5'd10, MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18,
                          MULHU = 5'd19, DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

   ex_muldiv #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr);
      bus.op_i   = op;
      bus.reg1_i = a;
      bus.reg2_i = b;
      bus.wd_i   = wd;
      bus.wreg_i = wr;
   endtask

   task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      drive(op, a, b, 5'd9, 1'b1);
      #1;
      chk(tag, bus.wdata_o, exp);
      chk({tag, "_ctl"}, {25'd0, bus.wd_o, bus.stall_req_o, bus.wreg_o}, {25'd0, 5'd9, 2'b01});
      tick;
   endtask

   // Issue an M-op at cycle 0 and watch cycles 0..lat for stall and the single result pulse.
   task automatic run_mop(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit hold);
      int          stalls = 0;
      int          pulses = 0;
      int          pcyc   = -1;
      logic [31:0] res    = '0;
      drive(op, a, b, 5'd11, 1'b1);
      #1;
      for (int c = 0; c <= lat; c++) begin
         if (bus.stall_req_o) stalls++;
         if (bus.wreg_o) begin
            pulses++;
            pcyc = c;
            res  = bus.wdata_o;
         end
         if (c == lat && !hold) drive(NOP, '0, '0, 5'd0, 1'b0);
         tick;
      end
      chk({tag, "_stalls"}, stalls, lat);
      chk({tag, "_pulse_cyc"}, pcyc, lat);
      chk({tag, "_pulses"}, pulses, 1);
      chk(tag, res, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int early;
      rst         = 1'b1;
      bus.flush_i = 1'b0;
      drive(ADD, 32'd3, 32'd4, 5'd3, 1'b1);
      tick;
      tick;
      chk("rst_wdata", bus.wdata_o, 32'h0);
      chk("rst_ctl", {25'd0, bus.wd_o, bus.stall_req_o, bus.wreg_o}, 32'h0);
      rst = 1'b0;
      drive(NOP, '0, '0, 5'd0, 1'b0);
      tick;

      alu("or",   OR_,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
      alu("and",  AND_, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
      alu("xor",  XOR_, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
      alu("add",  ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
      alu("sub",  SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
      alu("sll",  SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
      alu("srl",  SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
      alu("sra",  SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
      alu("slt",  SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
      alu("sltu", SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      alu("nop",  NOP,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
      alu("bad",  5'd12, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);

      run_mop("mul",    MUL,    32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33, 1'b0);
      run_mop("mulh",   MULH,   32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33, 1'b0);
      run_mop("mulhu",  MULHU,  32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33, 1'b0);
      run_mop("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33, 1'b0);
      run_mop("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
      run_mop("div",    DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
      run_mop("rem",    REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
      run_mop("divu",   DIVU,   32'd100, 32'd7, 32'd14, 33, 1'b0);
      run_mop("remu",   REMU,   32'd100, 32'd7, 32'd2, 33, 1'b0);

      run_mop("div_z",   DIV,  32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      run_mop("rem_z",   REM,  32'd5, 32'd0, 32'd5, 1, 1'b0);
      run_mop("divu_z",  DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      run_mop("div_ovf", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
      run_mop("rem_ovf", REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);

      // Identical MUL held across DONE must issue twice, each with its own stall window.
      run_mop("b2b_1", MUL, 32'd3, 32'd5, 32'd15, 33, 1'b1);
      run_mop("b2b_2", MUL, 32'd3, 32'd5, 32'd15, 33, 1'b0);

      // Flush in BUSY cycle 10.
      drive(MUL, 32'd7, 32'd9, 5'd4, 1'b1);
      #1;
      chk("flush_c0_stall", bus.stall_req_o, 32'd1);
      early = 0;
      for (int c = 1; c <= 10; c++) begin
         tick;
         if (bus.wreg_o) early++;
      end
      chk("flush_pre_pulses", early, 0);
      chk("flush_busy_stall", bus.stall_req_o, 32'd1);
      bus.flush_i = 1'b1;
      #1;
      chk("flush_cyc_ctl", {bus.stall_req_o, bus.wreg_o}, 32'd0);
      tick;
      bus.flush_i = 1'b0;
      drive(ADD, 32'd3, 32'd4, 5'd6, 1'b1);
      #1;
      chk("flush_add", bus.wdata_o, 32'd7);
      chk("flush_add_ctl", {bus.stall_req_o, bus.wreg_o}, 32'd1);
      tick;

      // Reset in the middle of BUSY.
      drive(MUL, 32'd3, 32'd5, 5'd8, 1'b1);
      #1;
      for (int c = 1; c <= 5; c++) tick;
      chk("rstb_busy_stall", bus.stall_req_o, 32'd1);
      rst = 1'b1;
      tick;
      chk("rstb_wdata", bus.wdata_o, 32'h0);
      chk("rstb_ctl", {25'd0, bus.wd_o, bus.stall_req_o, bus.wreg_o}, 32'h0);
      rst = 1'b0;
      drive(ADD, 32'd3, 32'd4, 5'd2, 1'b1);
      #1;
      chk("rstb_add", bus.wdata_o, 32'd7);
      chk("rstb_add_ctl", {bus.stall_req_o, bus.wreg_o}, 32'd1);
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
